// File: rtl/q22_pkg.sv
//==============================================================================
// Module      : q22_pkg
// Description : Shared Q2.2 / Q3.2 widths, limits and averager state encoding.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

package q22_pkg;

    localparam int Q22_W   = 5;
    localparam int Q32_W   = 6;
    localparam int Q22_MAX = 15;
    localparam int Q22_MIN = -16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/q22_saturate.sv
//==============================================================================
// Module      : q22_saturate
// Description : Combinational clip of a signed value to OUT_W bits, with sat flag.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module q22_saturate #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 5
) (
    input  logic signed [IN_W-1:0]  val_i,
    output logic        [OUT_W-1:0] val_o,
    output logic                    sat_o
);

    generate
        if (IN_W <= OUT_W) begin : g_width_check
            $error("q22_saturate: IN_W must exceed OUT_W");
        end
    endgenerate

    // The value fits iff every bit from the target sign bit upward is identical.
    logic [IN_W-OUT_W:0] w_upper;
    logic                w_fits;

    assign w_upper = val_i[IN_W-1:OUT_W-1];
    assign w_fits  = (&w_upper) | ~(|w_upper);

    always_comb begin
        sat_o = ~w_fits;
        val_o = val_i[OUT_W-1:0];
        if (!w_fits) begin
            if (val_i[IN_W-1]) begin
                val_o = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                val_o = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/q22_sum_averager.sv
//==============================================================================
// Module      : q22_sum_averager
// Description : Accumulates blocks of 2**LOG2_CNT Q3.2 sums, emits saturated Q2.2 mean.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module q22_sum_averager
    import q22_pkg::*;
#(
    parameter int SUM_W    = Q32_W,
    parameter int OUT_W    = Q22_W,
    parameter int LOG2_CNT = 2,
    parameter int ACC_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] sum_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] mean_out,
    output logic [ACC_W-1:0] acc_out,
    output logic             sat_out
);

    generate
        if (ACC_W < SUM_W + LOG2_CNT) begin : g_acc_width_check
            $error("q22_sum_averager: ACC_W too small for a full block");
        end
        if (LOG2_CNT < 1 || LOG2_CNT > 4) begin : g_cnt_range_check
            $error("q22_sum_averager: LOG2_CNT must be 1..4");
        end
    endgenerate

    localparam logic [LOG2_CNT-1:0] c_LAST = '1;

    state_t                    state_q,   state_d;
    logic signed [ACC_W-1:0]   acc_q,     acc_d;
    logic [LOG2_CNT-1:0]       cnt_q,     cnt_d;
    logic [OUT_W-1:0]          mean_q,    mean_d;
    logic [ACC_W-1:0]          acc_out_q, acc_out_d;
    logic                      sat_q,     sat_d;

    logic signed [ACC_W-1:0]   w_sum_ext;
    logic signed [ACC_W-1:0]   w_s;
    logic signed [ACC_W-1:0]   w_shift;
    logic [OUT_W-1:0]          w_mean_sat;
    logic                      w_sat;

    assign w_sum_ext = {{(ACC_W-SUM_W){sum_in[SUM_W-1]}}, sum_in};
    assign w_s       = acc_q + w_sum_ext;
    assign w_shift   = w_s >>> LOG2_CNT;

    q22_saturate #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .val_i (w_shift),
        .val_o (w_mean_sat),
        .sat_o (w_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            mean_q    <= '0;
            acc_out_q <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mean_q    <= mean_d;
            acc_out_q <= acc_out_d;
            sat_q     <= sat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mean_d    = mean_q;
        acc_out_d = acc_out_q;
        sat_d     = sat_q;

        if (clear) begin
            state_d   = IDLE;
            acc_d     = '0;
            cnt_d     = '0;
            mean_d    = '0;
            acc_out_d = '0;
            sat_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (cnt_q == c_LAST) begin
                            // Final sample bypasses acc and lands directly in the result.
                            state_d   = DONE;
                            acc_out_d = w_s;
                            mean_d    = w_mean_sat;
                            sat_d     = w_sat;
                            acc_d     = '0;
                            cnt_d     = '0;
                        end else begin
                            acc_d = w_s;
                            cnt_d = cnt_q + LOG2_CNT'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign mean_out  = mean_q;
    assign acc_out   = acc_out_q;
    assign sat_out   = sat_q;

endmodule

`default_nettype wire
